// File: rtl/set_assoc_cache_ctrl_pkg.sv
// Shared types and sizing helpers for the set-associative cache tag controller.
package cache_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_FLUSH
  } state_t;

  // Widest tag any configuration may use; narrower tags are zero-extended
  localparam int TAG_W_MAX = 32;

  // One way's entry for one set as seen on a read port
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
  } tag_entry_t;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int calc_sets(input int index_w);
    return 1 << index_w;
  endfunction

  // Victim pointer width; a direct-mapped cache still gets one (constant) bit
  function automatic int calc_ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/set_assoc_cache_ctrl_if.sv
// Request/response, refill and status signals of the cache tag controller.
interface set_assoc_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 21
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_ack;
  logic              flush;
  logic              flush_busy;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  // Driver / backing-memory side
  modport master (
    output req_valid, req_addr, mem_ack, flush,
    input  req_ready, resp_valid, resp_hit, mem_req, mem_req_addr,
           flush_busy, hit_count, miss_count
  );

  // Controller side
  modport slave (
    input  req_valid, req_addr, mem_ack, flush,
    output req_ready, resp_valid, resp_hit, mem_req, mem_req_addr,
           flush_busy, hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache_ctrl_tag_way.sv
// One way of the tag store: {valid, tag} per set in a block-RAM style array
// with a registered read port and a single write port shared by install and
// sweep clear (clear wins, the two never overlap in practice).
module cache_tag_way
  import cache_pkg::*;
#(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 16
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  output tag_entry_t         rd_entry,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               clr_en,
  input  logic [INDEX_W-1:0] clr_index
);
  localparam int SETS = calc_sets(INDEX_W);

  logic [TAG_W:0]     mem_array [SETS];
  logic [TAG_W:0]     rd_data_reg;
  logic               we_next;
  logic [INDEX_W-1:0] wa_next;
  logic [TAG_W:0]     wd_next;

  // Merge the install and clear requests onto the single write port
  always_comb begin
    we_next = clr_en | wr_en;
    wa_next = clr_en ? clr_index : wr_index;
    wd_next = clr_en ? '0 : {1'b1, wr_tag};
  end

  // RAM write
  always_ff @(posedge clk) begin
    if (we_next) mem_array[wa_next] <= wd_next;
  end

  // Registered read, captured when a request is accepted
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_reg <= mem_array[rd_index];
  end

  // Present the stored entry with the tag zero-extended to the shared width
  always_comb begin
    rd_entry       = '0;
    rd_entry.valid = rd_data_reg[TAG_W];
    rd_entry.tag   = TAG_W_MAX'(rd_data_reg[TAG_W-1:0]);
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative cache tag controller: hit/miss lookup, line refill
// over a req/ack handshake, round-robin replacement, flush sweep and
// saturating hit/miss counters.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 10,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 21
) (
  input logic                 clk,
  input logic                 rst_n,
  set_assoc_cache_ctrl_if.slave bus
);
  localparam int TAG_W  = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int PTR_W  = calc_ptr_w(WAYS);
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] sweep_idx_reg;
  logic [LINE_W-1:0]  line_reg;
  logic               pending_reg;
  logic [CNT_W-1:0]   hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0]   tag_cur;
  logic [INDEX_W-1:0] idx_cur, req_idx;
  logic               sweeping, accept, refill_done;
  logic               lookup_hit, all_valid;
  logic [PTR_W-1:0]   victim, ptr_rd;
  tag_entry_t         rd_entry [WAYS];
  logic [WAYS-1:0]    way_wr_en;

  assign tag_cur     = line_reg[LINE_W-1 -: TAG_W];
  assign idx_cur     = line_reg[INDEX_W-1:0];
  assign req_idx     = bus.req_addr[OFFSET_W +: INDEX_W];
  assign sweeping    = (state_reg == ST_INIT) || (state_reg == ST_FLUSH);
  assign accept      = (state_reg == ST_IDLE) && bus.req_valid && !bus.flush && !pending_reg;
  assign refill_done = (state_reg == ST_REFILL) && bus.mem_ack;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_wr_en[gi] = refill_done && (victim == PTR_W'(gi));
      cache_tag_way #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
      ) u_way (
        .clk       (clk),
        .rd_en     (accept),
        .rd_index  (req_idx),
        .rd_entry  (rd_entry[gi]),
        .wr_en     (way_wr_en[gi]),
        .wr_index  (idx_cur),
        .wr_tag    (tag_cur),
        .clr_en    (sweeping),
        .clr_index (sweep_idx_reg)
      );
    end

    if (WAYS > 1) begin : g_ptr
      logic [PTR_W-1:0] ptr_mem [calc_sets(INDEX_W)];
      logic [PTR_W-1:0] ptr_rd_reg;

      // Pointer store: cleared by the sweep, advanced only when a full set evicts
      always_ff @(posedge clk) begin
        if (sweeping) ptr_mem[sweep_idx_reg] <= '0;
        else if (refill_done && all_valid) ptr_mem[idx_cur] <= ptr_rd_reg + PTR_W'(1);
      end

      // Pointer read alongside the tag read at acceptance
      always_ff @(posedge clk) begin
        if (accept) ptr_rd_reg <= ptr_mem[req_idx];
      end

      assign ptr_rd = ptr_rd_reg;
    end else begin : g_no_ptr
      assign ptr_rd = '0;
    end
  endgenerate

  // Tag compare and victim choice: lowest invalid way, else the round-robin pointer
  always_comb begin
    lookup_hit = 1'b0;
    all_valid  = 1'b1;
    victim     = ptr_rd;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd_entry[w].valid && (rd_entry[w].tag == TAG_W_MAX'(tag_cur))) lookup_hit = 1'b1;
      if (!rd_entry[w].valid) begin
        all_valid = 1'b0;
        victim    = PTR_W'(w);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_INIT;
    else        state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT, ST_FLUSH: if (sweep_idx_reg == '1) state_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.flush || pending_reg) state_next = ST_FLUSH;
        else if (bus.req_valid)       state_next = ST_LOOKUP;
      end
      ST_LOOKUP: state_next = lookup_hit ? ST_IDLE : ST_REFILL;
      ST_REFILL: if (bus.mem_ack) state_next = ST_IDLE;
      default:   state_next = ST_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_hit     = 1'b0;
    bus.mem_req      = 1'b0;
    bus.flush_busy   = 1'b0;
    bus.mem_req_addr = {line_reg, {OFFSET_W{1'b0}}};
    case (state_reg)
      ST_INIT, ST_FLUSH: bus.flush_busy = 1'b1;
      ST_IDLE:           bus.req_ready  = !pending_reg && !bus.flush;
      ST_LOOKUP: begin
        bus.resp_valid = lookup_hit;
        bus.resp_hit   = lookup_hit;
      end
      ST_REFILL: begin
        bus.mem_req    = 1'b1;
        bus.resp_valid = bus.mem_ack;
      end
      default: ;
    endcase
  end

  // Sweep index walks every set during INIT/FLUSH and wraps back to zero
  always_ff @(posedge clk) begin
    if (!rst_n)        sweep_idx_reg <= '0;
    else if (sweeping) sweep_idx_reg <= sweep_idx_reg + INDEX_W'(1);
    else               sweep_idx_reg <= '0;
  end

  // Latch the line address of the accepted request
  always_ff @(posedge clk) begin
    if (accept) line_reg <= bus.req_addr[ADDR_W-1:OFFSET_W];
  end

  // Remember a flush that arrives while an access is in flight
  always_ff @(posedge clk) begin
    if (!rst_n)                     pending_reg <= 1'b0;
    else if (state_reg == ST_IDLE)  pending_reg <= 1'b0;
    else if (((state_reg == ST_LOOKUP) || (state_reg == ST_REFILL)) && bus.flush)
      pending_reg <= 1'b1;
  end

  // Saturating hit/miss counters, bumped on the lookup outcome
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == ST_LOOKUP) begin
      if (lookup_hit && (hit_cnt_reg != '1))    hit_cnt_reg  <= hit_cnt_reg + CNT_W'(1);
      if (!lookup_hit && (miss_cnt_reg != '1))  miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.hit_count  = hit_cnt_reg;
  assign bus.miss_count = miss_cnt_reg;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Self-checking bench: two controllers (wide and 2-bit counters) share one
// stimulus stream; expectations come from a set/way model of the cache.
module tb_set_assoc_cache_ctrl;
  localparam int ADDR_W = 32, OFFSET_W = 6, INDEX_W = 10, WAYS = 2;
  localparam int CNT_W = 21, CNT_W_S = 2;
  localparam int SETS = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;

  always #5 clk = ~clk;

  set_assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W))   bus_a();
  set_assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W_S)) bus_b();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.mem_ack   = mem_ack;
  assign bus_a.flush     = flush;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.mem_ack   = mem_ack;
  assign bus_b.flush     = flush;

  set_assoc_cache_ctrl #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                         .WAYS(WAYS), .CNT_W(CNT_W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  set_assoc_cache_ctrl #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
                         .WAYS(WAYS), .CNT_W(CNT_W_S)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Cache model: contents per set/way plus the round-robin pointer
  bit              m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag  [SETS][WAYS];
  int              m_ptr   [SETS];

  // Expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        e_ready, e_rv, e_rh, e_mreq, e_chk_mreq, e_busy;
  logic [31:0] e_maddr;
  int          hits_raw = 0, misses_raw = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] seen_maddr = '0;
  logic        last_rh = 1'b0;

  function automatic int set_of(input logic [31:0] a);
    return int'(a[OFFSET_W +: INDEX_W]);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int s, v;
    s = set_of(a);
    v = -1;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = tag_of(a);
  endfunction

  function automatic logic [31:0] sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? 32'(mx) : 32'(raw);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string p, input logic rdy, input logic rv, input logic rh,
                         input logic mreq, input logic [31:0] maddr, input logic busy,
                         input logic [31:0] hc, input logic [31:0] mc, input int w);
    chk({p, ".req_ready"},  32'(rdy),  32'(e_ready));
    chk({p, ".resp_valid"}, 32'(rv),   32'(e_rv));
    if (e_rv) chk({p, ".resp_hit"}, 32'(rh), 32'(e_rh));
    if (e_chk_mreq) chk({p, ".mem_req"}, 32'(mreq), 32'(e_mreq));
    if (e_chk_mreq && e_mreq) chk({p, ".mem_req_addr"}, maddr, e_maddr);
    chk({p, ".flush_busy"}, 32'(busy), 32'(e_busy));
    chk({p, ".hit_count"},  hc, sat(hits_raw, w));
    chk({p, ".miss_count"}, mc, sat(misses_raw, w));
  endtask

  // Compare both DUTs against the model on the falling edge of every checked cycle
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("a", bus_a.req_ready, bus_a.resp_valid, bus_a.resp_hit, bus_a.mem_req,
              bus_a.mem_req_addr, bus_a.flush_busy, 32'(bus_a.hit_count),
              32'(bus_a.miss_count), CNT_W);
      cmp_dut("b", bus_b.req_ready, bus_b.resp_valid, bus_b.resp_hit, bus_b.mem_req,
              bus_b.mem_req_addr, bus_b.flush_busy, 32'(bus_b.hit_count),
              32'(bus_b.miss_count), CNT_W_S);
      if (bus_a.mem_req)    seen_maddr = bus_a.mem_req_addr;
      if (bus_a.resp_valid) last_rh    = bus_a.resp_hit;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    e_ready = 1'b1; e_rv = 1'b0; e_rh = 1'b0; e_mreq = 1'b0;
    e_chk_mreq = 1'b1; e_busy = 1'b0;
  endtask

  // Called in the first INIT/FLUSH cycle; returns in the first IDLE cycle
  task automatic do_sweep(input bit stray_ack);
    model_clear();
    for (int i = 0; i < SETS; i++) begin
      e_ready = 1'b0; e_rv = 1'b0; e_mreq = 1'b0; e_chk_mreq = 1'b1; e_busy = 1'b1;
      mem_ack = stray_ack && (i < 3);
      cyc();
    end
    mem_ack = 1'b0;
    set_idle_exp();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    cyc();
    rst_n = 1'b1; hits_raw = 0; misses_raw = 0;
    do_sweep(1'b0);
  endtask

  task automatic idle(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      set_idle_exp();
      mem_ack = stray_ack;
      cyc();
      mem_ack = 1'b0;
    end
  endtask

  task automatic idle_flush(input bit with_req);
    flush = 1'b1; req_valid = with_req; req_addr = 32'h0001_0040;
    set_idle_exp(); e_ready = 1'b0;
    cyc();
    flush = 1'b0; req_valid = 1'b0;
    do_sweep(1'b0);
  endtask

  // One access from an IDLE cycle. flush_at: 0 = LOOKUP cycle, k = k-th refill
  // cycle, -1 none. rst_at: refill cycle index at which rst_n is pulsed, -1 none.
  task automatic access(input logic [31:0] addr, input int ack_dly, input int flush_at,
                        input int rst_at);
    bit hit, pend;
    pend = 1'b0;
    req_valid = 1'b1; req_addr = addr; set_idle_exp();
    cyc();
    req_valid = 1'b0; req_addr = $urandom;
    hit = model_hit(addr);
    e_ready = 1'b0; e_rv = hit; e_rh = 1'b1; e_mreq = 1'b0; e_chk_mreq = 1'b1;
    flush = (flush_at == 0); pend = (flush_at == 0);
    cyc();
    flush = 1'b0;
    if (hit) hits_raw++;
    else begin
      misses_raw++;
      for (int d = 0; d <= ack_dly; d++) begin
        e_rv = 1'b0; e_mreq = 1'b1; e_chk_mreq = 1'b1;
        e_maddr = {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
        if (d == ack_dly) begin
          mem_ack = 1'b1; e_rv = 1'b1; e_rh = 1'b0; e_chk_mreq = 1'b0;
        end
        if (d + 1 == flush_at) begin flush = 1'b1; pend = 1'b1; end
        if (d == rst_at) begin
          rst_n = 1'b0; mem_ack = 1'b0; e_rv = 1'b0; e_chk_mreq = 1'b1;
          cyc();
          rst_n = 1'b1; flush = 1'b0; hits_raw = 0; misses_raw = 0;
          do_sweep(1'b1);
          return;
        end
        cyc();
        flush = 1'b0; mem_ack = 1'b0;
      end
      model_fill(addr);
    end
    set_idle_exp();
    if (pend) begin
      e_ready = 1'b0;
      cyc();
      do_sweep(1'b0);
    end
  endtask

  initial begin
    logic [31:0] addr;
    int r;
    set_idle_exp();
    e_maddr = '0;
    // Test 1: reset release, 1024-cycle INIT sweep
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1; chk_en = 1'b1;
    do_sweep(1'b0);
    chk("t1_req_ready", 32'(bus_a.req_ready), 32'd1);
    chk("t1_hit_count", 32'(bus_a.hit_count), 32'd0);
    chk("t1_miss_count", 32'(bus_a.miss_count), 32'd0);

    // Test 2: miss with refill, then same-line hit
    access(32'h0001_0040, 3, -1, -1);
    chk("t2_mem_req_addr", seen_maddr, 32'h0001_0040);
    chk("t2_resp_hit_miss", 32'(last_rh), 32'd0);
    chk("t2_miss_count", 32'(bus_a.miss_count), 32'd1);
    access(32'h0001_007C, 0, -1, -1);
    chk("t2_resp_hit_hit", 32'(last_rh), 32'd1);
    chk("t2_hit_count", 32'(bus_a.hit_count), 32'd1);

    // Test 3: two-way set fill, round-robin eviction
    do_reset();
    access(32'h0001_0040, 1, -1, -1);
    access(32'h0002_0040, 1, -1, -1);
    access(32'h0001_0040, 0, -1, -1);
    access(32'h0002_0040, 0, -1, -1);
    access(32'h0003_0040, 1, -1, -1);
    access(32'h0001_0040, 2, -1, -1);
    access(32'h0003_0040, 0, -1, -1);
    chk("t3_resp_hit", 32'(last_rh), 32'd1);
    chk("t3_miss_count", 32'(bus_a.miss_count), 32'd4);
    chk("t3_hit_count", 32'(bus_a.hit_count), 32'd3);

    // Test 4: flush during refill, then the line is gone
    access(32'h0005_0080, 2, 2, -1);
    access(32'h0005_0080, 0, -1, -1);
    chk("t4_resp_hit", 32'(last_rh), 32'd0);
    chk("t4_miss_count", 32'(bus_a.miss_count), 32'd6);

    // Flush level in IDLE beats a simultaneous request
    idle_flush(1'b1);
    chk("flush_req_hit_count", 32'(bus_a.hit_count), 32'd3);

    // Test 5: reset in mid-refill, late ack during INIT
    access(32'h0007_00C0, 4, -1, 2);
    chk("t5_mem_req", 32'(bus_a.mem_req), 32'd0);
    chk("t5_miss_count", 32'(bus_a.miss_count), 32'd0);

    // Test 6: 2-bit counters saturate
    access(32'h0001_0040, 1, -1, -1);
    repeat (5) access(32'h0001_0040, 0, -1, -1);
    chk("t6_hit_count_sat", 32'(bus_b.hit_count), 32'd3);
    chk("t6_miss_count_sat", 32'(bus_b.miss_count), 32'd1);
    chk("t6_hit_count_wide", 32'(bus_a.hit_count), 32'd5);

    // Randomized traffic over a few conflicting sets
    for (int n = 0; n < 150; n++) begin
      addr = {16'($urandom_range(1, 5)), 10'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
      r = int'($urandom_range(0, 99));
      if (r < 3) idle_flush(r[0]);
      else access(addr, int'($urandom_range(0, 4)),
                  (r < 7) ? int'($urandom_range(0, 3)) : -1, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Run-time bound
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
